// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared definitions for the write-back stage: result-source
//               select encodings and the stage FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    // Result-source select carried with each EX instruction.
    // 2'b11 is reserved and decodes as ALU.
    localparam logic [1:0] WB_SEL_RS  = 2'b00;
    localparam logic [1:0] WB_SEL_ALU = 2'b01;
    localparam logic [1:0] WB_SEL_MEM = 2'b10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FULL     = 2'd1,
        WAIT_MEM = 2'd2
    } wb_state_t;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_result_mux.sv
`default_nettype none
// ============================================================================
// Module      : wb_result_mux
// Description : Combinational select of the value latched into the EX/WB
//               entry. RS selects the Rs operand; ALU, reserved 2'b11 and MEM
//               all pass the ALU result (MEM data is overwritten later by the
//               load return).
// Ports       : sel_i   - result-source select (wb_pkg encodings)
//               alu_i   - ALU result
//               rs_i    - Rs operand value
//               data_o  - selected value
// Revision    : 1.0 - initial release
// ============================================================================
module wb_result_mux
    import wb_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [1:0]    sel_i,
    input  logic [DW-1:0] alu_i,
    input  logic [DW-1:0] rs_i,
    output logic [DW-1:0] data_o
);

    assign data_o = (sel_i == WB_SEL_RS) ? rs_i : alu_i;

endmodule : wb_result_mux
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage
// Description : Write-back stage after EX. Holds one EX/WB entry, drives the
//               register-file write port, and stalls EX (ex_ready_o=0) while
//               a load is outstanding. Keeps a saturating count of cycles
//               spent waiting for load data.
// Config      : WB_BYPASS_EN - when defined, adds the fwd_* bypass port to
//               the hazard/forwarding logic.
// Ports       : clk, rst_n          - clock, async active-low reset
//               ex_*_i / ex_ready_o  - EX valid/ready handshake and payload
//               mem_rvalid_i/rdata_i - load data return
//               wb_we_o/rd_o/data_o  - register-file write port
//               stall_cnt_o          - saturating WAIT_MEM cycle count
//               fwd_*_o              - bypass port (WB_BYPASS_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
module wb_stage
    import wb_pkg::*;
#(
    parameter int DW      = 8,
    parameter int RW      = 3,
    parameter int R0_ZERO = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid_i,
    output logic             ex_ready_o,
    input  logic [DW-1:0]    ex_alu_data_i,
    input  logic [DW-1:0]    ex_rs_data_i,
    input  logic [RW-1:0]    ex_rd_i,
    input  logic [1:0]       ex_sel_i,
    input  logic             ex_reg_write_i,
    input  logic             mem_rvalid_i,
    input  logic [DW-1:0]    mem_rdata_i,
    output logic             wb_we_o,
    output logic [RW-1:0]    wb_rd_o,
    output logic [DW-1:0]    wb_data_o,
`ifdef WB_BYPASS_EN
    output logic             fwd_valid_o,
    output logic             fwd_pend_o,
    output logic [RW-1:0]    fwd_rd_o,
    output logic [DW-1:0]    fwd_data_o,
`endif
    output logic [CNT_W-1:0] stall_cnt_o
);

    wb_state_t        state_q;
    logic [RW-1:0]    rd_q;
    logic             reg_write_q;
    logic [DW-1:0]    data_q;
    logic [CNT_W-1:0] stall_cnt_q;

    logic [DW-1:0]    sel_data_d;
    logic             accept_d;

    wb_result_mux #(
        .DW (DW)
    ) u_result_mux (
        .sel_i  (ex_sel_i),
        .alu_i  (ex_alu_data_i),
        .rs_i   (ex_rs_data_i),
        .data_o (sel_data_d)
    );

    // Ready depends on state only so there is no combinational path back
    // into EX through ex_valid_i.
    assign ex_ready_o = (state_q != WAIT_MEM);
    assign accept_d   = ex_valid_i && ex_ready_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            data_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE, FULL: begin
                    // FULL retires its entry this cycle, so a new instruction
                    // can be taken back-to-back without a bubble.
                    if (accept_d) begin
                        rd_q        <= ex_rd_i;
                        reg_write_q <= ex_reg_write_i;
                        data_q      <= sel_data_d;
                        state_q     <= (ex_sel_i == WB_SEL_MEM) ? WAIT_MEM : FULL;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                WAIT_MEM: begin
                    if (stall_cnt_q != {CNT_W{1'b1}}) begin
                        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
                    end
                    if (mem_rvalid_i) begin
                        data_q  <= mem_rdata_i;
                        state_q <= FULL;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign wb_we_o     = (state_q == FULL) && reg_write_q
                         && !((R0_ZERO != 0) && (rd_q == '0));
    assign wb_rd_o     = rd_q;
    assign wb_data_o   = data_q;
    assign stall_cnt_o = stall_cnt_q;

`ifdef WB_BYPASS_EN
    assign fwd_valid_o = wb_we_o;
    // While waiting, rd_q already holds the load destination, so the hazard
    // unit can use fwd_rd_o to stall dependants.
    assign fwd_pend_o  = (state_q == WAIT_MEM) && reg_write_q;
    assign fwd_rd_o    = rd_q;
    assign fwd_data_o  = data_q;
`endif

endmodule : wb_stage
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_stage
// Description : Self-checking bench for wb_stage. A table of single-cycle
//               instructions plus hand-written load/reset sequences; expected
//               register-file writes are queued with their due cycle and
//               checked by a monitor. A second instance (R0_ZERO=0, CNT_W=3)
//               shares the stimulus for the R0 and saturation cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_stage;
    import wb_pkg::*;

    localparam int DW = 8;
    localparam int RW = 3;

    logic          clk;
    logic          rst_n;
    logic          ex_valid;
    logic [DW-1:0] ex_alu_data;
    logic [DW-1:0] ex_rs_data;
    logic [RW-1:0] ex_rd;
    logic [1:0]    ex_sel;
    logic          ex_reg_write;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;

    logic          ex_ready_a, ex_ready_b;
    logic          wb_we_a, wb_we_b;
    logic [RW-1:0] wb_rd_a, wb_rd_b;
    logic [DW-1:0] wb_data_a, wb_data_b;
    logic [15:0]   cnt_a;
    logic [2:0]    cnt_b;
`ifdef WB_BYPASS_EN
    logic          fv_a, fp_a, fv_b, fp_b;
    logic [RW-1:0] frd_a, frd_b;
    logic [DW-1:0] fd_a, fd_b;
`endif

    wb_stage #(.DW(DW), .RW(RW), .R0_ZERO(1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid_i(ex_valid), .ex_ready_o(ex_ready_a),
        .ex_alu_data_i(ex_alu_data), .ex_rs_data_i(ex_rs_data),
        .ex_rd_i(ex_rd), .ex_sel_i(ex_sel), .ex_reg_write_i(ex_reg_write),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .wb_we_o(wb_we_a), .wb_rd_o(wb_rd_a), .wb_data_o(wb_data_a),
`ifdef WB_BYPASS_EN
        .fwd_valid_o(fv_a), .fwd_pend_o(fp_a), .fwd_rd_o(frd_a), .fwd_data_o(fd_a),
`endif
        .stall_cnt_o(cnt_a)
    );

    wb_stage #(.DW(DW), .RW(RW), .R0_ZERO(0), .CNT_W(3)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .ex_valid_i(ex_valid), .ex_ready_o(ex_ready_b),
        .ex_alu_data_i(ex_alu_data), .ex_rs_data_i(ex_rs_data),
        .ex_rd_i(ex_rd), .ex_sel_i(ex_sel), .ex_reg_write_i(ex_reg_write),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .wb_we_o(wb_we_b), .wb_rd_o(wb_rd_b), .wb_data_o(wb_data_b),
`ifdef WB_BYPASS_EN
        .fwd_valid_o(fv_b), .fwd_pend_o(fp_b), .fwd_rd_o(frd_b), .fwd_data_o(fd_b),
`endif
        .stall_cnt_o(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct {
        logic [RW-1:0] rd;
        logic [DW-1:0] data;
        int            due;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [1:0]    sel;
        logic [RW-1:0] rd;
        logic [DW-1:0] alu;
        logic [DW-1:0] rs;
        logic          rw;
        logic          exp_we;
        logic [DW-1:0] exp_data;
    } vec_t;
    vec_t tbl[8];

    // Write monitor for the main instance.
    always @(negedge clk) begin
        if (rst_n && wb_we_a) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", {24'd0, 5'd0, wb_rd_a}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wb_rd", 32'(wb_rd_a), 32'(e.rd));
                chk("wb_data", 32'(wb_data_a), 32'(e.data));
                chk("wb_cycle", 32'(cyc), 32'(e.due));
`ifdef WB_BYPASS_EN
                chk("fwd_valid", 32'(fv_a), 32'd1);
                chk("fwd_data", 32'(fd_a), 32'(e.data));
                chk("fwd_rd", 32'(frd_a), 32'(e.rd));
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic [RW-1:0] rd,
                         input logic [DW-1:0] alu, input logic [DW-1:0] rs, input logic rw);
        ex_valid     = v;
        ex_sel       = sel;
        ex_rd        = rd;
        ex_alu_data  = alu;
        ex_rs_data   = rs;
        ex_reg_write = rw;
    endtask

    initial begin
        tbl[0] = '{WB_SEL_ALU, 3'd1, 8'h11, 8'h00, 1'b1, 1'b1, 8'h11};
        tbl[1] = '{WB_SEL_ALU, 3'd2, 8'h22, 8'h01, 1'b1, 1'b1, 8'h22};
        tbl[2] = '{WB_SEL_ALU, 3'd3, 8'h33, 8'h02, 1'b1, 1'b1, 8'h33};
        tbl[3] = '{WB_SEL_RS,  3'd4, 8'h99, 8'h44, 1'b1, 1'b1, 8'h44};
        tbl[4] = '{2'b11,      3'd5, 8'h55, 8'h66, 1'b1, 1'b1, 8'h55};
        tbl[5] = '{WB_SEL_ALU, 3'd6, 8'hC3, 8'h00, 1'b0, 1'b0, 8'h00};
        tbl[6] = '{WB_SEL_ALU, 3'd0, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00};
        tbl[7] = '{WB_SEL_RS,  3'd7, 8'h12, 8'h77, 1'b1, 1'b1, 8'h77};

        rst_n      = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        drive(1'b0, WB_SEL_ALU, '0, '0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        chk("rst_wb_we", 32'(wb_we_a), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd_a), 32'd0);
        chk("rst_wb_data", 32'(wb_data_a), 32'd0);
        chk("rst_ex_ready", 32'(ex_ready_a), 32'd1);
        chk("rst_stall_cnt", 32'(cnt_a), 32'd0);
`ifdef WB_BYPASS_EN
        chk("rst_fwd_pend", 32'(fp_a), 32'd0);
        chk("rst_fwd_valid", 32'(fv_a), 32'd0);
`endif
        rst_n = 1'b1;
        step();

        // Reset while a load is pending: the load is dropped
        drive(1'b1, WB_SEL_MEM, 3'd3, 8'h01, 8'h02, 1'b1);
        step();
        drive(1'b0, WB_SEL_ALU, '0, '0, '0, 1'b0);
        chk("mid_load_ready", 32'(ex_ready_a), 32'd0);
        step();
        step();
        rst_n = 1'b0;
        #2;
        chk("async_rst_ready", 32'(ex_ready_a), 32'd1);
        chk("async_rst_cnt", 32'(cnt_a), 32'd0);
        chk("async_rst_rd", 32'(wb_rd_a), 32'd0);
        rst_n = 1'b1;
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 8'hAA;
        step();
        mem_rvalid = 1'b0;
        chk("post_rst_ready", 32'(ex_ready_a), 32'd1);
        chk("post_rst_cnt", 32'(cnt_a), 32'd0);
        chk("post_rst_we", 32'(wb_we_a), 32'd0);
        chk("post_rst_data", 32'(wb_data_a), 32'd0);
        step();

        // Table: one accept per cycle, back-to-back
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, tbl[i].sel, tbl[i].rd, tbl[i].alu, tbl[i].rs, tbl[i].rw);
            chk("tbl_ex_ready", 32'(ex_ready_a), 32'd1);
            if (tbl[i].exp_we) sb.push_back('{tbl[i].rd, tbl[i].exp_data, cyc + 1});
            step();
        end
        // mem_rvalid outside WAIT_MEM must have no effect
        drive(1'b0, WB_SEL_ALU, '0, '0, '0, 1'b0);
        mem_rvalid = 1'b1;
        mem_rdata  = 8'hEE;
        step();
        mem_rvalid = 1'b0;
        chk("rvalid_idle_data", 32'(wb_data_a), 32'h77);
        step();

        // R0 write: suppressed with R0_ZERO=1, performed with R0_ZERO=0
        drive(1'b1, WB_SEL_ALU, 3'd0, 8'hFF, 8'h00, 1'b1);
        step();
        drive(1'b0, WB_SEL_ALU, '0, '0, '0, 1'b0);
        @(negedge clk);
        chk("r0_we_zero1", 32'(wb_we_a), 32'd0);
        chk("r0_we_zero0", 32'(wb_we_b), 32'd1);
        chk("r0_data_zero0", 32'(wb_data_b), 32'hFF);
        step();

        // Load stall: rvalid pulse in accept cycle ignored, data after 4 cycles
        drive(1'b1, WB_SEL_MEM, 3'd5, 8'h10, 8'h20, 1'b1);
        mem_rvalid = 1'b1;
        mem_rdata  = 8'h13;
        step();
        drive(1'b0, WB_SEL_ALU, '0, '0, '0, 1'b0);
        mem_rvalid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            chk("load_ex_ready", 32'(ex_ready_a), 32'd0);
            if (k == 4) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 8'h5A;
                sb.push_back('{3'd5, 8'h5A, cyc + 1});
            end
            step();
        end
        mem_rvalid = 1'b0;
        chk("load_stall_cnt", 32'(cnt_a), 32'd4);
        chk("load_ready_after", 32'(ex_ready_a), 32'd1);
        step();

        // Long load to rd=6: counter saturation on the CNT_W=3 instance
        drive(1'b1, WB_SEL_MEM, 3'd6, 8'h00, 8'h00, 1'b1);
        step();
        drive(1'b0, WB_SEL_ALU, '0, '0, '0, 1'b0);
`ifdef WB_BYPASS_EN
        chk("fwd_pend", 32'(fp_a), 32'd1);
        chk("fwd_pend_rd", 32'(frd_a), 32'd6);
        chk("fwd_valid_pend", 32'(fv_a), 32'd0);
`endif
        repeat (10) step();
        chk("sat_cnt_w3", 32'(cnt_b), 32'd7);
        chk("cnt_w16", 32'(cnt_a), 32'd14);
        chk("sat_ex_ready", 32'(ex_ready_a), 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 8'h3C;
        sb.push_back('{3'd6, 8'h3C, cyc + 1});
        step();
        mem_rvalid = 1'b0;
        step();
        step();
        chk("sat_cnt_hold", 32'(cnt_b), 32'd7);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_wb_stage
`default_nettype wire

// File: doc/wb_stage.md
# wb_stage

Parametrised write-back stage sitting after EX in the pipeline. It holds one registered EX/WB entry and selects the write-back value from the ALU result, the Rs operand or load data from memory. It drives the register-file write port and stalls EX with a valid/ready handshake while a load is outstanding. A saturating stall counter and an optional bypass port to the hazard/forwarding logic are included.

## Interface
Parameters:
- DW, 8, data width of register-file values
- RW, 3, register-number width (2**RW registers)
- R0_ZERO, 1, when 1, writes to register 0 are suppressed
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EX presents a valid instruction
- ex_ready  out  1  stage accepts the EX instruction this cycle
- ex_alu_data  in  DW  ALU result
- ex_rs_data  in  DW  Rs operand value
- ex_rd  in  RW  destination register
- ex_sel  in  2  result source, values from wb_pkg
- ex_reg_write  in  1  instruction writes the register file
- mem_rvalid  in  1  load data valid
- mem_rdata  in  DW  load data
- wb_we  out  1  register-file write enable
- wb_rd  out  RW  register-file write address
- wb_data  out  DW  register-file write data
- stall_cnt  out  CNT_W  saturating count of WAIT_MEM cycles
- fwd_valid, fwd_pend  out  1 each  bypass port, present only with the macro (see Configuration)
- fwd_rd  out  RW  bypass port, present only with the macro
- fwd_data  out  DW  bypass port, present only with the macro

## Operation
- Accept = ex_valid && ex_ready. On accept, the stage latches rd, reg_write and sel. It also latches the selected value: ALU for sel ALU or reserved 2'b11, Rs for sel RS.
- States: IDLE, FULL, WAIT_MEM.
- IDLE:
  - ex_ready=1.
  - On accept, go to WAIT_MEM if sel==MEM, otherwise go to FULL.
- FULL:
  - The entry retires this cycle and ex_ready=1.
  - On accept, go to WAIT_MEM or FULL depending on the new sel (back-to-back, no bubble).
  - Otherwise go to IDLE.
- WAIT_MEM:
  - ex_ready=0.
  - mem_rvalid=1 latches mem_rdata into the entry and moves to FULL.
  - mem_rvalid is sampled only in WAIT_MEM. A pulse in the accept cycle is ignored.
- wb_we = (state==FULL) && reg_write && !(R0_ZERO && rd==0). wb_rd and wb_data are the registered entry and are valid whenever wb_we=1.
- stall_cnt increments by 1 every cycle in WAIT_MEM and saturates at all-ones (no wrap). It is never cleared except by reset.
- When the entry has reg_write=0, it still occupies FULL for one cycle with wb_we=0.

## Timing
- Latency: ALU/RS instruction accepted at edge N gives wb_we high in cycle N+1. A load with mem_rvalid seen in cycle M writes in cycle M+1.
- Throughput: 1 instruction/cycle without loads.
- Reset (asynchronous, any state):
  - State goes to IDLE, and all entry fields and stall_cnt go to 0.
  - wb_we=0, wb_rd=0, wb_data=0, ex_ready=1 (combinational from IDLE).
  - All bypass outputs go to 0.
  - A load pending in WAIT_MEM is dropped. A later mem_rvalid is ignored.
- ex_ready is a function of state only, never of ex_valid (no combinational loop to EX).
- When ex_valid=0 and mem_rvalid=1 in IDLE/FULL, mem_rvalid has no effect.

## Configuration
- WB_BYPASS_EN defined:
  - fwd_valid = wb_we, fwd_rd = wb_rd, fwd_data = wb_data, all the same cycle.
  - fwd_pend = (state==WAIT_MEM) && reg_write. fwd_rd then shows the pending load destination so the hazard unit can stall dependants.
- WB_BYPASS_EN undefined: the fwd_* ports and their logic are absent. All other behaviour is identical.

## Structure
- Package wb_pkg:
  - Select constants WB_SEL_RS=2'b00, WB_SEL_ALU=2'b01, WB_SEL_MEM=2'b10. 2'b11 is reserved and decodes as ALU.
  - State typedef wb_state_t {IDLE, FULL, WAIT_MEM}.
- Sub-module wb_result_mux: a combinational, DW-parametrised select of ALU/RS by ex_sel, instantiated once ahead of the entry register.
- The FSM, entry register and counter live in wb_stage.

## Test plan
- Reset mid-load: accept a load with rd=3, assert rst_n=0 in WAIT_MEM, release, then pulse mem_rvalid with 0xAA -> state IDLE, wb_we never asserts, stall_cnt=0.
- Back-to-back ALU: 3 consecutive accepts, sel ALU, rd=1,2,3, data 0x11,0x22,0x33 -> wb_we high 3 consecutive cycles starting N+1 with matching rd/data, ex_ready constantly 1.
- Load stall: accept sel MEM rd=5, mem_rvalid after 4 cycles with 0x5A -> ex_ready=0 for 4 cycles, stall_cnt=4, wb_we with rd=5/0x5A on the following cycle.
- R0 suppression: R0_ZERO=1, ALU write rd=0 data 0xFF -> wb_we=0. Repeat with R0_ZERO=0 -> wb_we=1.
- Counter saturation: CNT_W=3, hold WAIT_MEM for 10 cycles -> stall_cnt stops at 7.
- Bypass (WB_BYPASS_EN): during a load to rd=6, fwd_pend=1 with fwd_rd=6. On write, fwd_valid=1 with fwd_data equal to wb_data. Reserved sel 2'b11 selects the ALU value.
